mips_avalon_master: RTL
=======================

Name: mips_avalon_master

Overview:
- Avalon memory-mapped master that bridges the MIPS CPU's simple load/store request interface onto the Avalon bus used by the test memory slave.
- Generates word-aligned address, byteenable and lane-replicated writedata for byte/half/word accesses.
- Honours waitrequest and returns aligned, sign- or zero-extended load data.
- Detects misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 64: max consecutive cycles waitrequest may stay high before the transaction aborts with error; 0 disables the timeout.
- CHECK_ALIGN, 1: 1 = misaligned half/word requests fault without any bus activity; 0 = the address is forced aligned (low bits ignored).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  CPU request present
- req_ready  output  1  master can accept a request (high only in IDLE)
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal and faults
- req_signed  input  1  sign-extend load result (lb/lh)
- resp_valid  output  1  one-cycle pulse, transaction finished
- resp_rdata  output  32  load result, valid with resp_valid (0 for stores and errors)
- resp_error  output  1  with resp_valid: misaligned, illegal size or timeout
- address  output  32  Avalon address, always {req_addr[31:2],2'b00}
- read  output  1  Avalon read
- write  output  1  Avalon write
- writedata  output  32  Avalon write data
- byteenable  output  4  Avalon byte enables
- waitrequest  input  1  Avalon stall from slave
- readdata  input  32  Avalon read data

Behaviour:
- Reset: state IDLE; read=write=0; address=0; writedata=0; byteenable=0; resp_valid=0; resp_rdata=0; resp_error=0; req_ready=1; timeout counter=0.
- Accept: on a rising edge with req_valid & req_ready, latch the request.
  - Legal request: go to BUS. read or write is asserted from the next cycle.
  - Fault (size 3, or CHECK_ALIGN and half with addr[0]=1 or word with addr[1:0]!=0): go to RESP with error=1. read and write are never asserted.
- Byteenable:
  - byte: 4'b0001 << addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- Writedata:
  - byte: wdata[7:0] replicated x4
  - half: wdata[15:0] replicated x2
  - word: as-is
- BUS: address, read/write, byteenable and writedata are registered and held stable while waitrequest=1.
  - read and write are never both high.
  - Completion edge: read|write high and waitrequest low. readdata is sampled at this edge. read/write drop next cycle. Go to RESP.
- Timeout: counter increments on each BUS cycle with waitrequest=1.
  - When it reaches TIMEOUT (TIMEOUT>0), deassert read/write, go to RESP with error=1. readdata is discarded.
  - The counter clears on accept.
- Load extraction: select the byte lane (addr[1:0]) or half lane (addr[1]) from the sampled readdata. Sign-extend if req_signed, else zero-extend. Word returns as-is.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in BUS and RESP.
  - Minimum latency, accept edge to resp_valid: 2 cycles with zero-wait slave; 1 cycle for a fault.
- Reset mid-transaction: read/write drop on the reset edge. No response pulse is produced. The aborted transaction is lost.
- req_valid held while busy is ignored (not queued). The requester holds until req_ready.

Decomposition:
- Package mips_avalon_pkg:
  - size_t enum: SIZE_BYTE, SIZE_HALF, SIZE_WORD
  - state_t enum: IDLE, BUS, RESP
  - function for byteenable generation
- One combinational sub-module, mips_avalon_lane: lane select plus sign/zero extension for loads, and writedata replication for stores. Shared with future cache work.

Test Plan:
- sw addr 0x10 data 0xDEADBEEF, slave WRITE_DELAY=2 -> write held with byteenable=4'b1111 until waitrequest low; one resp_valid, resp_error=0; memory[4]=0xDEADBEEF.
- sb addr 0x13 data 0x000000AA -> byteenable=4'b1000, writedata=0xAAAAAAAA; memory word becomes 0xAAADBEEF.
- lb signed addr 0x13 -> resp_rdata=0xFFFFFFAA. lhu addr 0x12 -> 0x0000AAAD. lh addr 0x10 -> 0xFFFFBEEF.
- lw from 0xBFC00000 with READ_DELAY=1 and READ_DELAY=3 -> resp_rdata equals instruction word 0; read deasserts the cycle after completion; no write pulse.
- lw addr 0x11 (CHECK_ALIGN=1) -> resp_valid with resp_error=1 one cycle after accept; read/write stay 0 throughout.
- Slave holding waitrequest=1, TIMEOUT=16 -> read drops and resp_error=1 after 16 stalled cycles. Separately, reset asserted in BUS -> all outputs at reset values next cycle, no resp_valid.

Source files
------------

// File: rtl/mips_avalon_pkg.sv
// Shared types and helpers for the MIPS load/store to Avalon master bridge.
package mips_avalon_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Request fields kept after accept for load extraction
    typedef struct packed {
        logic       write;
        logic [1:0] size;
        logic [1:0] addr_lo;
        logic       is_signed;
    } req_t;

    function automatic logic [BE_W-1:0] gen_byteenable(input logic [1:0] size,
                                                       input logic [1:0] addr_lo);
        logic [BE_W-1:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << addr_lo;
            SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mips_avalon_lane.sv
// Byte-lane steering: load extraction with sign/zero extension, store replication.
module mips_avalon_lane
    import mips_avalon_pkg::*;
(
    input  logic [1:0]        ld_size,
    input  logic [1:0]        ld_addr_lo,
    input  logic              ld_signed,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        st_size,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data_c,
    output logic [DATA_W-1:0] store_data_c
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        case (ld_addr_lo)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (ld_size)
            SIZE_BYTE: load_data_c = {{24{ld_signed & ld_byte[7]}}, ld_byte};
            SIZE_HALF: load_data_c = {{16{ld_signed & ld_half[15]}}, ld_half};
            default:   load_data_c = rdata;
        endcase
    end

    // Replicate so the slave sees the data on whichever lane byteenable selects
    always_comb begin
        case (st_size)
            SIZE_BYTE: store_data_c = {4{wdata[7:0]}};
            SIZE_HALF: store_data_c = {2{wdata[15:0]}};
            default:   store_data_c = wdata;
        endcase
    end

endmodule

// File: rtl/mips_avalon_master.sv
// Avalon-MM master bridging the CPU load/store request port onto the memory bus,
// with alignment checking and a waitrequest timeout.
module mips_avalon_master
    import mips_avalon_pkg::*;
#(
    parameter int unsigned TIMEOUT     = 64,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1) + 1;

    state_t            state_q, state_d;
    req_t              req_q, req_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              read_d, write_d, resp_valid_d, resp_error_d, req_ready_d;
    logic [31:0]       address_d, writedata_d, resp_rdata_d;
    logic [3:0]        byteenable_d;

    logic              fault;
    logic [31:0]       load_data_c;
    logic [31:0]       store_data_c;

    mips_avalon_lane u_lane (
        .ld_size      (req_q.size),
        .ld_addr_lo   (req_q.addr_lo),
        .ld_signed    (req_q.is_signed),
        .rdata        (readdata),
        .st_size      (req_size),
        .wdata        (req_wdata),
        .load_data_c  (load_data_c),
        .store_data_c (store_data_c)
    );

    // Illegal size always faults; misalignment only when checking is enabled
    always_comb begin
        fault = (req_size == 2'd3);
        if (CHECK_ALIGN) begin
            if (req_size == SIZE_HALF && req_addr[0])
                fault = 1'b1;
            if (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)
                fault = 1'b1;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        cnt_d        = cnt_q;
        read_d       = read;
        write_d      = write;
        address_d    = address;
        writedata_d  = writedata;
        byteenable_d = byteenable;
        req_ready_d  = req_ready;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_error_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    req_d.write     = req_write;
                    req_d.size      = req_size;
                    req_d.addr_lo   = req_addr[1:0];
                    req_d.is_signed = req_signed;
                    cnt_d           = '0;
                    req_ready_d     = 1'b0;
                    if (fault) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end else begin
                        state_d      = BUS;
                        read_d       = ~req_write;
                        write_d      = req_write;
                        address_d    = {req_addr[31:2], 2'b00};
                        byteenable_d = gen_byteenable(req_size, req_addr[1:0]);
                        writedata_d  = req_write ? store_data_c : '0;
                    end
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = req_q.write ? '0 : load_data_c;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (TIMEOUT != 0 && cnt_d == CNT_W'(TIMEOUT)) begin
                        read_d       = 1'b0;
                        write_d      = 1'b0;
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                read_d      = 1'b0;
                write_d     = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= '0;
            cnt_q      <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            address    <= '0;
            writedata  <= '0;
            byteenable <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            read       <= read_d;
            write      <= write_d;
            address    <= address_d;
            writedata  <= writedata_d;
            byteenable <= byteenable_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            resp_error <= resp_error_d;
        end
    end

endmodule
